// File: rtl/bcd_seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
// All segment codes are active-low {g,f,e,d,c,b,a}.
package bcd_seg_pkg;

  localparam int IDX_W = 2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Entry n holds the active-low pattern for digit n; the highest index is listed first.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Codes A-F are not valid BCD and display a dash.
module bcd_to_seg
  import bcd_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) begin
      seg = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode display showing a 3-digit BCD value.
// The value is snapshotted once per frame; leading zeros are blanked; each slot opens dark.
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] num,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(3);

  logic [CNT_W-1:0] tick_cnt;
  logic [IDX_W-1:0] idx;
  logic [11:0]      snap;
  logic             tick;

  logic [3:0] digit;
  logic [6:0] digit_seg;
  logic       blank_hund;
  logic       blank_tens;
  logic       lit;
  logic [3:0] an_next;
  logic [6:0] seg_next;

  assign tick = (tick_cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      idx        <= '0;
      snap       <= 12'h000;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (tick) begin
        tick_cnt <= '0;
        idx      <= idx + 1'b1;
        // Snapshot at the end of the dark slot so the whole next frame is consistent.
        if (idx == IDX_LAST) begin
          snap       <= num;
          frame_tick <= 1'b1;
        end
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    digit = 4'h0;
    case (idx)
      2'd0:    digit = snap[3:0];
      2'd1:    digit = snap[7:4];
      2'd2:    digit = snap[11:8];
      default: digit = 4'h0;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (digit),
    .seg (digit_seg)
  );

  // Invalid codes count as non-zero, so only a true 0 nibble blanks.
  assign blank_hund = (BLANK_LZ != 0) && (snap[11:8] == 4'h0);
  assign blank_tens = blank_hund && (snap[7:4] == 4'h0);

  always_comb begin
    lit = (idx != IDX_LAST) && (tick_cnt >= CNT_W'(GUARD));
    if (idx == 2'd1 && blank_tens) lit = 1'b0;
    if (idx == 2'd2 && blank_hund) lit = 1'b0;
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    if (lit) begin
      an_next  = ~(4'b0001 << idx);
      seg_next = digit_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
